tdm_one_to_four_demux: RTL
==========================

Name: tdm_one_to_four_demux

Overview:
- Receive end of the 4:1 time-division link: one shared data bus carries channels d0..d3 in slots {s1,s0} = 00, 01, 10, 11.
- Tracks the slot with its own counter, locked by a frame-start marker, and stages each slot into its channel register.
- Presents all four channels together once per complete frame.
- Sits between the TDM link and per-channel consumers; the transmitter side is the existing 4:1 mux driven by a slot counter.

Parameters:
- DATA_W, 1, width of each channel sample and of the link bus.
- ERR_CNT_W, 8, width of the saturating sync-error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  link word present this cycle.
- in_data  input  DATA_W  link word for the current slot.
- frame_start  input  1  qualified by in_valid; marks the word as slot 00.
- d0  output  DATA_W  channel 0 sample of the last complete frame.
- d1  output  DATA_W  channel 1 sample of the last complete frame.
- d2  output  DATA_W  channel 2 sample of the last complete frame.
- d3  output  DATA_W  channel 3 sample of the last complete frame.
- frame_valid  output  1  one-cycle pulse when d0..d3 update.
- slot  output  2  {s1,s0} expected for the next accepted word; 00 in HUNT.
- locked  output  1  high in LOCKED.
- sync_err  output  1  one-cycle pulse on a frame_start arriving mid-frame.
- err_count  output  ERR_CNT_W  saturating count of sync_err events.

Behaviour:
- Reset (rst high at a clk edge) forces the following, and overrides all other inputs that cycle, including mid-frame:
  - d0..d3 = 0, staging registers = 0.
  - frame_valid = 0, sync_err = 0, slot = 00, err_count = 0.
  - state = HUNT, locked = 0.
- Words are accepted only when in_valid = 1; frame_start with in_valid = 0 is ignored.
- HUNT state:
  - Words without frame_start are discarded.
  - A word with frame_start goes to stage0; slot becomes 01; state goes to LOCKED.
- LOCKED state, word accepted, frame_start = 0:
  - Store into stage[slot], then slot increments mod 4.
  - If slot was 11: d0..d3 load stage0..2 plus the current in_data in the same edge, frame_valid pulses for the next cycle, slot wraps to 00.
- LOCKED state, word accepted, frame_start = 1:
  - If slot = 00: normal slot-0 capture.
  - If slot != 00: sync_err pulses, err_count increments (saturating at all-ones), partial frame is discarded with no frame_valid, the word is stored as stage0, slot becomes 01.
- Latency:
  - d0..d3 and frame_valid change at the clk edge that accepts the slot-11 word.
  - frame_valid is high for exactly the following cycle.
- d0..d3 hold their values between frames; staging never leaks to outputs before a frame completes.
- Gaps: in_valid low for any number of cycles pauses the slot counter; lock is retained.
- locked = 1 from the edge that accepts the first frame_start until reset; lock is not dropped on sync_err, the demux resyncs instead.
- Back-to-back frames at full rate give one frame_valid pulse every 4 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package/header holds:
  - State encodings HUNT = 1'b0, LOCKED = 1'b1.
  - Slot constants SLOT0..SLOT3 = 2'b00..2'b11, shared with the transmitter's slot counter.
  - Default DATA_W.
- One natural sub-module, tdm_slot_counter: 2-bit counter with enable, synchronous load-to-01, synchronous clear, and a wrap flag; instantiated once.
- Staging, output registers, FSM and error counter stay in the top.

Test Plan:
- Reset then lock (DATA_W=4): rst high 2 cycles; send frame_start word 4'hA, then 4'h5, 4'h3, 4'hC, all in_valid=1 -> d0=A, d1=5, d2=3, d3=C; frame_valid single pulse after the 4th word; locked=1; err_count=0.
- HUNT discard: before any frame_start send words 4'h1, 4'h2, then a full frame 7,8,9,E -> d0..d3 = 7,8,9,E; only one frame_valid.
- Gaps: frame 1,2,3,4 with in_valid low 3 cycles between every word -> same outputs as the gapless frame; slot steps 01, 10, 11, 00 only on accepted words.
- Mid-frame resync: locked, send 6, 7 (slot now 10), then frame_start with F, followed by 0, 1, 2 -> sync_err pulse; err_count=1; no frame_valid for the 6/7 partial frame; d0..d3 = F,0,1,2.
- Reset mid-frame: after two words of a frame, rst for 1 cycle -> d0..d3=0, locked=0, slot=00; a subsequent frame without frame_start produces no frame_valid.
- Saturation (ERR_CNT_W=2): force 5 mid-frame frame_starts -> err_count goes 1, 2, 3, 3, 3; sync_err pulses 5 times.

Source files
------------

// File: rtl/tdm_one_to_four_demux_pkg.sv
// Shared definitions for the 4:1 TDM link: receiver FSM states and slot codes
// (slot codes match the transmitter's slot counter).
package tdm_one_to_four_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] SLOT0 = 2'b00;
  localparam logic [1:0] SLOT1 = 2'b01;
  localparam logic [1:0] SLOT2 = 2'b10;
  localparam logic [1:0] SLOT3 = 2'b11;

  localparam int DEFAULT_DATA_W = 1;

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit slot counter: clear to slot 0, load to slot 1 (word just taken as slot 0),
// or step on enable; wrap flags the step out of the last slot.
module tdm_slot_counter
  import tdm_one_to_four_demux_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       en,
  output logic [1:0] cnt,
  output logic       wrap
);

  always_ff @(posedge clk) begin
    if (clr)       cnt <= SLOT0;
    else if (load) cnt <= SLOT1;
    else if (en)   cnt <= cnt + 2'd1;
  end

  assign wrap = en && !load && (cnt == SLOT3);

endmodule

// File: rtl/tdm_one_to_four_demux.sv
// Receive side of the 4:1 TDM link: locks to frame_start, stages slots 0..2 and
// publishes all four channels together when the slot-3 word arrives.
module tdm_one_to_four_demux
  import tdm_one_to_four_demux_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 frame_start,
  output logic [DATA_W-1:0]    d0,
  output logic [DATA_W-1:0]    d1,
  output logic [DATA_W-1:0]    d2,
  output logic [DATA_W-1:0]    d3,
  output logic                 frame_valid,
  output logic [1:0]           slot,
  output logic                 locked,
  output logic                 sync_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t                 state;
  logic [2:0][DATA_W-1:0] stage;
  logic                   fs_acc, resync, cnt_load, cnt_en, wrap;

  assign fs_acc   = in_valid && frame_start;
  // A marker anywhere but slot 0 while locked restarts the frame from this word.
  assign resync   = fs_acc && (state == LOCKED) && (slot != SLOT0);
  assign cnt_load = fs_acc && ((state == HUNT) || resync);
  assign cnt_en   = in_valid && (state == LOCKED);

  tdm_slot_counter u_slot (
    .clk  (clk),
    .clr  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .cnt  (slot),
    .wrap (wrap)
  );

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      stage       <= '0;
      d0          <= '0;
      d1          <= '0;
      d2          <= '0;
      d3          <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (frame_start) begin
              stage[0] <= in_data;
              state    <= LOCKED;
            end
          end
          LOCKED: begin
            if (resync) begin
              sync_err <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
              stage[0] <= in_data;
            end else if (wrap) begin
              d0          <= stage[0];
              d1          <= stage[1];
              d2          <= stage[2];
              d3          <= in_data;
              frame_valid <= 1'b1;
            end else begin
              case (slot)
                SLOT0:   stage[0] <= in_data;
                SLOT1:   stage[1] <= in_data;
                default: stage[2] <= in_data;
              endcase
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
